// File: rtl/excess3_bcd_codec_seq.sv
// ---------------------------------------------------------------------------
// excess3_bcd_codec_seq
//
// Digit-serial converter between excess-3 and BCD for a packed word of
// NUM_DIGITS 4-bit codes. A word is accepted in IDLE, converted one digit per
// clock in CONV (digit 0 first), then presented in DONE until the sink takes
// it. Each digit that is not a legal code for the selected direction is
// replaced by 4'hF and flagged in err_mask.
//
// Parameters:
//   NUM_DIGITS  digits per word (1..16); data width W = 4*NUM_DIGITS
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input word available
//   in_ready   block can accept a word (high only in IDLE)
//   in_mode    0 = excess-3 -> BCD, 1 = BCD -> excess-3; sampled with in_data
//   in_data    packed codes, digit 0 in bits [3:0]
//   out_valid  result word available (high in DONE)
//   out_ready  sink accepts result
//   out_data   converted digits, same packing as in_data
//   err_mask   bit i set = digit i was an invalid code
//   err        OR of err_mask
//   busy       high in CONV or DONE
//   err_count  (E3_ERR_COUNT_EN only) saturating count of flagged digits
//              over all words handed to the sink
//
// Optional feature macro: E3_ERR_COUNT_EN
// ---------------------------------------------------------------------------
module excess3_bcd_codec_seq #(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic [4*NUM_DIGITS-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] out_data,
    output logic [NUM_DIGITS-1:0]   err_mask,
    output logic                    err,
`ifdef E3_ERR_COUNT_EN
    output logic [15:0]             err_count,
`endif
    output logic                    busy
);

    localparam int W     = 4 * NUM_DIGITS;
    // A one-digit word still needs a (constant zero) index register.
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q,  state_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic [W-1:0]          data_q,   data_d;
    logic                  mode_q,   mode_d;
    logic [W-1:0]          result_q, result_d;
    logic [NUM_DIGITS-1:0] errm_q,   errm_d;

    // -----------------------------------------------------------------------
    // Single-digit conversion. Returns {error, code}. Digits never interact,
    // so the arithmetic is plain 4-bit with no carry between digits.
    // -----------------------------------------------------------------------
    function automatic logic [4:0] convert_digit(input logic       mode,
                                                 input logic [3:0] code);
        logic [4:0] res;
        res = {1'b1, 4'hF};
        if (!mode) begin
            // excess-3 -> BCD: only 3..12 encode a decimal digit
            if (code >= 4'd3 && code <= 4'd12) begin
                res = {1'b0, code - 4'd3};
            end
        end else begin
            // BCD -> excess-3: only 0..9 are decimal digits
            if (code <= 4'd9) begin
                res = {1'b0, code + 4'd3};
            end
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Split the captured word into digits so the current one can be picked
    // with a plain index compare.
    // -----------------------------------------------------------------------
    logic [3:0] digit_code [NUM_DIGITS];

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_code[gi] = data_q[gi*4 +: 4];
        end
    endgenerate

    logic [3:0] cur_code;
    logic [4:0] cur_conv;

    always_comb begin
        cur_code = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_code = digit_code[i];
            end
        end
    end

    assign cur_conv = convert_digit(mode_q, cur_code);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        data_d   = data_q;
        mode_d   = mode_q;
        result_d = result_q;
        errm_d   = errm_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d   = in_data;
                    mode_d   = in_mode;
                    result_d = '0;
                    errm_d   = '0;
                    idx_d    = '0;
                    state_d  = CONV;
                end
            end

            CONV: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        result_d[i*4 +: 4] = cur_conv[3:0];
                        errm_d[i]          = cur_conv[4];
                    end
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            DONE: begin
                // Result stays frozen here and in IDLE afterwards.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            data_q   <= '0;
            mode_q   <= 1'b0;
            result_q <= '0;
            errm_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            errm_q   <= errm_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. in_ready and out_valid come from mutually exclusive states,
    // so an input and an output handshake can never coincide.
    // -----------------------------------------------------------------------
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = result_q;
    assign err_mask  = errm_q;
    assign err       = |errm_q;

`ifdef E3_ERR_COUNT_EN
    // -----------------------------------------------------------------------
    // Running count of flagged digits, updated when a word leaves DONE.
    // -----------------------------------------------------------------------
    logic [15:0] err_count_q, err_count_d;
    logic [4:0]  word_errs;
    logic [16:0] count_sum;

    always_comb begin
        word_errs = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            word_errs = word_errs + {4'd0, errm_q[i]};
        end
    end

    assign count_sum = {1'b0, err_count_q} + {12'd0, word_errs};

    always_comb begin
        err_count_d = err_count_q;
        if (state_q == DONE && out_ready) begin
            err_count_d = count_sum[16] ? 16'hFFFF : count_sum[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_excess3_bcd_codec_seq.sv
// ---------------------------------------------------------------------------
// Directed bench for excess3_bcd_codec_seq: a 4-digit instance for the main
// function, backpressure and mid-conversion reset, and a 1-digit instance
// for back-to-back words.
// ---------------------------------------------------------------------------
module tb_excess3_bcd_codec_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 4-digit instance
    logic        in_valid4, in_ready4, in_mode4;
    logic [15:0] in_data4;
    logic        out_valid4, out_ready4;
    logic [15:0] out_data4;
    logic [3:0]  err_mask4;
    logic        err4, busy4;
`ifdef E3_ERR_COUNT_EN
    logic [15:0] err_count4;
    logic [15:0] err_count1;
`endif

    // 1-digit instance
    logic        in_valid1, in_ready1, in_mode1;
    logic [3:0]  in_data1;
    logic        out_valid1, out_ready1;
    logic [3:0]  out_data1;
    logic [0:0]  err_mask1;
    logic        err1, busy1;

    excess3_bcd_codec_seq #(.NUM_DIGITS(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_mode   (in_mode4),
        .in_data   (in_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4),
        .err_mask  (err_mask4),
        .err       (err4),
`ifdef E3_ERR_COUNT_EN
        .err_count (err_count4),
`endif
        .busy      (busy4)
    );

    excess3_bcd_codec_seq #(.NUM_DIGITS(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_mode   (in_mode1),
        .in_data   (in_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1),
        .err_mask  (err_mask1),
        .err       (err1),
`ifdef E3_ERR_COUNT_EN
        .err_count (err_count1),
`endif
        .busy      (busy1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one word on the 4-digit instance and follow it into DONE.
    task automatic run4(input string tag, input logic mode, input logic [15:0] din,
                        input logic [15:0] exp_out, input logic [3:0] exp_mask);
        check({tag, ".in_ready"}, 32'(in_ready4), 32'd1);
        in_valid4 = 1'b1;
        in_mode4  = mode;
        in_data4  = din;
        @(posedge clk); #1;
        // Scramble inputs after the accept edge; they must be ignored.
        in_valid4 = 1'b0;
        in_mode4  = ~mode;
        in_data4  = 16'hBEEF;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("%s.out_valid@%0d", tag, k), 32'(out_valid4), 32'(k == 4));
        end
        check({tag, ".out_data"}, 32'(out_data4), 32'(exp_out));
        check({tag, ".err_mask"}, 32'(err_mask4), 32'(exp_mask));
        check({tag, ".err"}, 32'(err4), 32'(exp_mask != 4'b0));
        check({tag, ".in_ready_done"}, 32'(in_ready4), 32'd0);
        check({tag, ".busy_done"}, 32'(busy4), 32'd1);
        $display("txn %s: mode=%0d in=%h out=%h err_mask=%b err=%0d",
                 tag, mode, din, out_data4, err_mask4, err4);
    endtask

    task automatic handshake4(input string tag);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        check({tag, ".hs_out_valid"}, 32'(out_valid4), 32'd0);
        check({tag, ".hs_in_ready"}, 32'(in_ready4), 32'd1);
        check({tag, ".hs_busy"}, 32'(busy4), 32'd0);
    endtask

    // One word on the 1-digit instance with out_ready held high.
    task automatic run1(input string tag, input logic [3:0] din,
                        input logic [3:0] exp_out, input logic exp_err);
        check({tag, ".in_ready"}, 32'(in_ready1), 32'd1);
        in_valid1 = 1'b1;
        in_mode1  = 1'b0;
        in_data1  = din;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        check({tag, ".out_valid_conv"}, 32'(out_valid1), 32'd0);
        @(posedge clk); #1;
        check({tag, ".out_valid"}, 32'(out_valid1), 32'd1);
        check({tag, ".out_data"}, 32'(out_data1), 32'(exp_out));
        check({tag, ".err"}, 32'(err1), 32'(exp_err));
        $display("txn %s: mode=0 in=%h out=%h err=%0d", tag, din, out_data1, err1);
        @(posedge clk); #1;
        check({tag, ".out_valid_after"}, 32'(out_valid1), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] held_data;

    initial begin
        rst        = 1'b1;
        in_valid4  = 1'b0; in_mode4 = 1'b0; in_data4 = '0; out_ready4 = 1'b0;
        in_valid1  = 1'b0; in_mode1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;

        // Reset state
        @(posedge clk); #1;
        check("rst.in_ready", 32'(in_ready4), 32'd1);
        check("rst.out_valid", 32'(out_valid4), 32'd0);
        check("rst.out_data", 32'(out_data4), 32'd0);
        check("rst.err_mask", 32'(err_mask4), 32'd0);
        check("rst.err", 32'(err4), 32'd0);
        check("rst.busy", 32'(busy4), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Main function, both directions
        run4("e3_6543", 1'b0, 16'h6543, 16'h3210, 4'b0000);
        handshake4("e3_6543");
`ifdef E3_ERR_COUNT_EN
        check("e3_6543.err_count", 32'(err_count4), 32'd0);
`endif
        run4("e3_3C2F", 1'b0, 16'h3C2F, 16'h09FF, 4'b0011);
        handshake4("e3_3C2F");
`ifdef E3_ERR_COUNT_EN
        check("e3_3C2F.err_count", 32'(err_count4), 32'd2);
`endif
        run4("bcd_9870", 1'b1, 16'h9870, 16'hCBA3, 4'b0000);
        handshake4("bcd_9870");
        run4("bcd_00A0", 1'b1, 16'h00A0, 16'h33F3, 4'b0010);

        // Backpressure: hold DONE for 10 cycles, offer a competing word
        for (int c = 0; c < 10; c++) begin
            in_valid4 = (c == 3);
            in_mode4  = 1'b0;
            in_data4  = 16'h1234;
            @(posedge clk); #1;
            check($sformatf("bp.out_valid@%0d", c), 32'(out_valid4), 32'd1);
            check($sformatf("bp.out_data@%0d", c), 32'(out_data4), 32'h33F3);
            check($sformatf("bp.err_mask@%0d", c), 32'(err_mask4), 32'b0010);
            check($sformatf("bp.in_ready@%0d", c), 32'(in_ready4), 32'd0);
        end
        in_valid4 = 1'b0;
        handshake4("bp");
        check("bp.idle_out_data", 32'(out_data4), 32'h33F3);
        check("bp.idle_err_mask", 32'(err_mask4), 32'b0010);
`ifdef E3_ERR_COUNT_EN
        check("bp.err_count", 32'(err_count4), 32'd3);
`endif

        // Reset in the 2nd CONV cycle
        in_valid4 = 1'b1; in_mode4 = 1'b0; in_data4 = 16'h6547;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        @(posedge clk); #1;
        check("mid.partial_out_data", 32'(out_data4), 32'h0004);
        check("mid.busy", 32'(busy4), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid.rst_out_data", 32'(out_data4), 32'd0);
        check("mid.rst_err_mask", 32'(err_mask4), 32'd0);
        check("mid.rst_busy", 32'(busy4), 32'd0);
        check("mid.rst_in_ready", 32'(in_ready4), 32'd1);
        check("mid.rst_out_valid", 32'(out_valid4), 32'd0);
`ifdef E3_ERR_COUNT_EN
        check("mid.rst_err_count", 32'(err_count4), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        run4("e3_4444", 1'b0, 16'h4444, 16'h1111, 4'b0000);
        handshake4("e3_4444");

        // One-digit instance, back-to-back
        run1("n1_3", 4'h3, 4'h0, 1'b0);
        run1("n1_C", 4'hC, 4'h9, 1'b0);
        run1("n1_2", 4'h2, 4'hF, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
